vertex_update_rmw: RTL

Single-lane read-modify-write engine that applies incoming vertex updates to the banked vertex buffer. It consumes update tuples (destination vertex address, update value), issues a read on one buffer read port, combines the returned vertex value with the update (add or unsigned min), and writes the result back on the matching buffer write port. Same-address hazards are resolved by stalling, so back-to-back updates to one vertex are never lost.

---
 rtl/vertex_update_rmw.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/vertex_update_rmw.sv
`default_nettype none
// ============================================================================
// Module      : vertex_update_rmw
// Description : Single-lane read-modify-write engine for the banked vertex
//               buffer. Reads the stored vertex value, combines it with the
//               update (wrapping add or unsigned min) and writes it back.
//               Same-address hazards stall in the hold register.
// Revision    : 1.0 - initial release
// ============================================================================
module vertex_update_rmw #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 2,
  parameter int OP     = 0
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  input  logic              upd_valid,
  output logic              upd_ready,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_data,
  output logic [ADDR_W-1:0] R_Addr,
  output logic              R_valid,
  input  logic [DATA_W-1:0] R_Data,
  input  logic              R_out_valid,
  output logic [ADDR_W-1:0] W_Addr,
  output logic [DATA_W-1:0] W_Data,
  output logic              W_valid,
  output logic              busy,
  output logic              err
);

  // Hold register: the single update waiting to issue its read
  logic              hold_valid_q, hold_valid_d;
  logic [ADDR_W-1:0] hold_addr_q,  hold_addr_d;
  logic [DATA_W-1:0] hold_data_q,  hold_data_d;

  // In-flight pipe: one stage per cycle of buffer read latency
  logic [RD_LAT-1:0]             pipe_valid_q, pipe_valid_d;
  logic [RD_LAT-1:0][ADDR_W-1:0] pipe_addr_q,  pipe_addr_d;
  logic [RD_LAT-1:0][DATA_W-1:0] pipe_data_q,  pipe_data_d;

  // Write stage drives the buffer write port directly
  logic              wr_valid_q, wr_valid_d;
  logic [ADDR_W-1:0] wr_addr_q,  wr_addr_d;
  logic [DATA_W-1:0] wr_data_q,  wr_data_d;

  logic              err_q, err_d;

  logic [RD_LAT-1:0] stage_hit;
  logic              hazard;
  logic              issue;
  logic              accept;
  logic              tail_valid;
  logic [ADDR_W-1:0] tail_addr;
  logic [DATA_W-1:0] tail_data;
  logic [DATA_W-1:0] combined;

  assign tail_valid = pipe_valid_q[RD_LAT-1];
  assign tail_addr  = pipe_addr_q[RD_LAT-1];
  assign tail_data  = pipe_data_q[RD_LAT-1];

  // Per-stage address match against the held update
  for (genvar s = 0; s < RD_LAT; s++) begin : g_stage_hit
    assign stage_hit[s] = pipe_valid_q[s] && (pipe_addr_q[s] == hold_addr_q);
  end

  // Combine function selected at elaboration time
  if (OP == 0) begin : g_op_add
    assign combined = R_Data + tail_data;   // carry is dropped by the width
  end else begin : g_op_min
    assign combined = (R_Data < tail_data) ? R_Data : tail_data;
  end

  // Stall while the same vertex is anywhere between read issue and write
  always_comb begin
    hazard = (|stage_hit) || (wr_valid_q && (wr_addr_q == hold_addr_q));
    issue  = hold_valid_q && !hazard;
    accept = upd_valid && upd_ready;
  end

  // Next-state logic for hold register, pipe, write stage and error flag
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_addr_d  = hold_addr_q;
    hold_data_d  = hold_data_q;
    if (accept) begin
      // Also covers accept-and-issue in the same cycle: hold reloads
      hold_valid_d = 1'b1;
      hold_addr_d  = upd_addr;
      hold_data_d  = upd_data;
    end else if (issue) begin
      hold_valid_d = 1'b0;
    end

    pipe_valid_d    = pipe_valid_q;
    pipe_addr_d     = pipe_addr_q;
    pipe_data_d     = pipe_data_q;
    pipe_valid_d[0] = issue;
    pipe_addr_d[0]  = hold_addr_q;
    pipe_data_d[0]  = hold_data_q;
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_valid_d[i] = pipe_valid_q[i-1];
      pipe_addr_d[i]  = pipe_addr_q[i-1];
      pipe_data_d[i]  = pipe_data_q[i-1];
    end

    // Write stage follows the pipe tail; a stray R_out_valid is ignored
    wr_valid_d = tail_valid;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (tail_valid) begin
      wr_addr_d = tail_addr;
      wr_data_d = combined;
    end

    err_d = err_q || (R_out_valid != tail_valid);
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid_q <= 1'b0;
      hold_addr_q  <= '0;
      hold_data_q  <= '0;
      pipe_valid_q <= '0;
      pipe_addr_q  <= '0;
      pipe_data_q  <= '0;
      wr_valid_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_addr_q  <= hold_addr_d;
      hold_data_q  <= hold_data_d;
      pipe_valid_q <= pipe_valid_d;
      pipe_addr_q  <= pipe_addr_d;
      pipe_data_q  <= pipe_data_d;
      wr_valid_q   <= wr_valid_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
    end
  end

  // Output drive
  always_comb begin
    upd_ready = !hold_valid_q || issue;
    R_valid   = issue;
    R_Addr    = hold_addr_q;
    W_valid   = wr_valid_q;
    W_Addr    = wr_addr_q;
    W_Data    = wr_data_q;
    busy      = hold_valid_q || (|pipe_valid_q) || wr_valid_q;
    err       = err_q;
  end

endmodule
`default_nettype wire
